dfi_phy_handshake: RTL and testbench
====================================

Name: dfi_phy_handshake

Overview:
- PHY-side responder for the DFI control handshakes: controller update, PHY update, PHY master and low-power control/data.
- Sits between the DFI boundary (memory-controller side) and the PHY's internal update/training logic.
- Converts internal PHY trigger pulses into DFI request/acknowledge sequences.
- Acknowledges controller-initiated requests with programmable latency.

Parameters:
- CTRLUPD_ACK_DLY, 2: cycles from ctrlupd_req high to ctrlupd_ack high (range 1..15).
- PHYUPD_HOLD, 4: cycles phyupd_req stays high after phyupd_ack is sampled high (range 1..255).
- PHYMSTR_HOLD, 4: same as PHYUPD_HOLD, for phymstr_req.
- LP_ACK_DLY, 1: cycles from lp_*_req high to lp_*_ack high (range 1..15).

Ports:
- clock  in  1  single clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- ctrlupd_req  in  1  controller update request.
- ctrlupd_ack  out  1  controller update acknowledge.
- phyupd_trig  in  1  internal one-cycle pulse starting a PHY update.
- phyupd_type_in  in  2  update type, captured with phyupd_trig.
- phyupd_req  out  1  PHY update request.
- phyupd_type  out  2  registered PHY update type.
- phyupd_ack  in  1  controller acknowledge of PHY update.
- phymstr_trig  in  1  internal one-cycle pulse starting a PHY-master request.
- phymstr_type_in  in  2  captured with phymstr_trig.
- phymstr_cs_state_in  in  2  captured with phymstr_trig.
- phymstr_state_sel_in  in  1  captured with phymstr_trig.
- phymstr_req  out  1  PHY master request.
- phymstr_type  out  2  registered PHY master type.
- phymstr_cs_state  out  2  registered CS state.
- phymstr_state_sel  out  1  registered state select.
- phymstr_ack  in  1  controller acknowledge of PHY master.
- lp_ctrl_req  in  1  low-power control request.
- lp_ctrl_wakeup  in  6  wakeup code for lp_ctrl.
- lp_ctrl_ack  out  1  low-power control acknowledge.
- lp_data_req  in  1  low-power data request.
- lp_data_wakeup  in  6  wakeup code for lp_data.
- lp_data_ack  out  1  low-power data acknowledge.
- lp_ctrl_wakeup_q  out  6  wakeup code registered when lp_ctrl_ack rises.
- lp_data_wakeup_q  out  6  wakeup code registered when lp_data_ack rises.
- busy  out  1  high while any update or PHY-master FSM is not IDLE.

Behaviour:
- Reset: every output is 0, every FSM is IDLE and every counter is 0. Reset mid-operation drops all requests and acks on the next edge.
- Controller update FSM (IDLE, WAIT, ACK):
  - IDLE to WAIT on ctrlupd_req=1, but only while the phyupd and phymstr FSMs are IDLE.
  - WAIT counts CTRLUPD_ACK_DLY cycles, then moves to ACK with ctrlupd_ack=1.
  - ACK holds ack while req=1; ack drops on the edge after req is sampled 0.
  - Req falling during WAIT returns to IDLE without ever asserting ack.
- PHY update FSM (IDLE, REQ, HOLD, DROP):
  - A trig pulse in IDLE captures the type and sets phyupd_req=1 on the next edge.
  - A trig pulse outside IDLE is ignored.
  - A trig pulse while the ctrlupd FSM is not IDLE is ignored (controller update wins simultaneous events).
  - REQ waits for phyupd_ack=1, with no timeout.
  - HOLD keeps req=1 for PHYUPD_HOLD cycles, then req drops.
  - DROP waits for ack=0, then returns to IDLE.
  - phyupd_type stays stable from req rise until return to IDLE, then clears to 0.
- PHY master FSM: identical to the PHY update FSM using the phymstr_* signals and PHYMSTR_HOLD.
  - phyupd and phymstr are mutually exclusive: a trig pulse while the other FSM is busy is ignored.
  - If both trig pulses arrive in the same cycle, phyupd wins.
- Low-power ctrl and data: two independent identical channels.
  - Ack rises LP_ACK_DLY cycles after req is sampled 1.
  - The wakeup code is registered in the same edge that ack rises.
  - Ack stays high while req=1 and drops on the edge after req is sampled 0.
  - Req falling before ack returns the channel to idle with no ack.
  - Wakeup changes while ack is high are ignored.
- Low-power channels are independent of the update FSMs.

Decomposition:
- Package dfi_phy_pkg holds:
  - FSM state enums for the update FSMs and the low-power channel.
  - 2-bit type typedefs.
  - Default delay constants.
- One sub-module, dfi_lp_chan, is instantiated twice (ctrl and data). It holds the req→delayed ack logic and the wakeup capture.

Test Plan:
- ctrlupd_req held high 10 cycles, delay 2: ctrlupd_ack is 1 from cycle 2 after req rises and 0 one cycle after req falls.
- phyupd_trig with type 2'b10, phyupd_ack driven 3 cycles later: phyupd_req=1 with type 2'b10 stable, req drops after 4 cycles of ack, FSM back to IDLE after ack falls.
- phymstr_trig with cs_state 2'b01, state_sel 1, type 2'b11: outputs match the captured values and follow the handshake; a second trig mid-handshake is ignored.
- ctrlupd_req and phyupd_trig in the same cycle: ctrlupd_ack asserted and phyupd_req stays 0.
- lp_ctrl_req high with wakeup 6'h15, LP_ACK_DLY=1: ack rises 1 cycle later and lp_ctrl_wakeup_q=6'h15; a req pulse shorter than the delay gives no ack.
- reset asserted during phyupd HOLD: all outputs 0 on the next edge.

Source files
------------

// File: rtl/dfi_phy_handshake_pkg.sv
// Shared types and default timing constants for the DFI PHY-side handshake responder.
package dfi_phy_pkg;

  typedef enum logic [1:0] {
    CU_IDLE = 2'd0,
    CU_WAIT = 2'd1,
    CU_ACK  = 2'd2
  } ctrlupd_state_e;

  typedef enum logic [1:0] {
    PU_IDLE = 2'd0,
    PU_REQ  = 2'd1,
    PU_HOLD = 2'd2,
    PU_DROP = 2'd3
  } phy_state_e;

  typedef enum logic [1:0] {
    LP_IDLE = 2'd0,
    LP_WAIT = 2'd1,
    LP_ACK  = 2'd2
  } lp_state_e;

  typedef logic [1:0] upd_type_t;
  typedef logic [1:0] cs_state_t;
  typedef logic [5:0] wakeup_t;

  typedef struct packed {
    upd_type_t typ;
    cs_state_t cs_state;
    logic      state_sel;
  } phymstr_info_t;

  localparam int unsigned CTRLUPD_ACK_DLY_DEF = 2;
  localparam int unsigned PHYUPD_HOLD_DEF     = 4;
  localparam int unsigned PHYMSTR_HOLD_DEF    = 4;
  localparam int unsigned LP_ACK_DLY_DEF      = 1;

endpackage

// File: rtl/dfi_phy_handshake_if.sv
// DFI handshake signals between the memory controller / PHY trigger logic and the responder.
interface dfi_phy_handshake_if;
  import dfi_phy_pkg::*;

  logic      ctrlupd_req;
  logic      ctrlupd_ack;

  logic      phyupd_trig;
  upd_type_t phyupd_type_in;
  logic      phyupd_req;
  upd_type_t phyupd_type;
  logic      phyupd_ack;

  logic      phymstr_trig;
  upd_type_t phymstr_type_in;
  cs_state_t phymstr_cs_state_in;
  logic      phymstr_state_sel_in;
  logic      phymstr_req;
  upd_type_t phymstr_type;
  cs_state_t phymstr_cs_state;
  logic      phymstr_state_sel;
  logic      phymstr_ack;

  logic      lp_ctrl_req;
  wakeup_t   lp_ctrl_wakeup;
  logic      lp_ctrl_ack;
  wakeup_t   lp_ctrl_wakeup_q;
  logic      lp_data_req;
  wakeup_t   lp_data_wakeup;
  logic      lp_data_ack;
  wakeup_t   lp_data_wakeup_q;

  logic      busy;

  modport master (
    output ctrlupd_req, phyupd_trig, phyupd_type_in, phyupd_ack,
    output phymstr_trig, phymstr_type_in, phymstr_cs_state_in, phymstr_state_sel_in, phymstr_ack,
    output lp_ctrl_req, lp_ctrl_wakeup, lp_data_req, lp_data_wakeup,
    input  ctrlupd_ack, phyupd_req, phyupd_type,
    input  phymstr_req, phymstr_type, phymstr_cs_state, phymstr_state_sel,
    input  lp_ctrl_ack, lp_ctrl_wakeup_q, lp_data_ack, lp_data_wakeup_q, busy
  );

  modport slave (
    input  ctrlupd_req, phyupd_trig, phyupd_type_in, phyupd_ack,
    input  phymstr_trig, phymstr_type_in, phymstr_cs_state_in, phymstr_state_sel_in, phymstr_ack,
    input  lp_ctrl_req, lp_ctrl_wakeup, lp_data_req, lp_data_wakeup,
    output ctrlupd_ack, phyupd_req, phyupd_type,
    output phymstr_req, phymstr_type, phymstr_cs_state, phymstr_state_sel,
    output lp_ctrl_ack, lp_ctrl_wakeup_q, lp_data_ack, lp_data_wakeup_q, busy
  );

endinterface

// File: rtl/dfi_phy_handshake_lp_chan.sv
// One low-power channel: acknowledges a held request after ACK_DLY cycles and latches its wakeup code.
module dfi_lp_chan
  import dfi_phy_pkg::*;
#(
  parameter int unsigned ACK_DLY = LP_ACK_DLY_DEF
) (
  input  logic    clock,
  input  logic    reset,
  input  logic    req,
  input  wakeup_t wakeup,
  output logic    ack,
  output wakeup_t wakeup_q
);

  localparam logic [3:0] DLY_LOAD = 4'(ACK_DLY - 1);

  lp_state_e  state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  wakeup_t    wake_q, wake_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= LP_IDLE;
      cnt_q   <= '0;
      wake_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wake_q  <= wake_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wake_d  = wake_q;
    case (state_q)
      LP_IDLE: begin
        if (req) begin
          state_d = LP_WAIT;
          cnt_d   = DLY_LOAD;
        end
      end
      LP_WAIT: begin
        // A request withdrawn before the delay expires is never acknowledged
        if (!req) begin
          state_d = LP_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == 4'd0) begin
          state_d = LP_ACK;
          wake_d  = wakeup;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      LP_ACK: begin
        if (!req) state_d = LP_IDLE;
      end
      default: begin
        state_d = LP_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign ack      = (state_q == LP_ACK);
  assign wakeup_q = wake_q;

endmodule

// File: rtl/dfi_phy_handshake.sv
// PHY-side DFI responder: controller update ack, PHY update / PHY master requests, low-power acks.
module dfi_phy_handshake
  import dfi_phy_pkg::*;
#(
  parameter int unsigned CTRLUPD_ACK_DLY = CTRLUPD_ACK_DLY_DEF,
  parameter int unsigned PHYUPD_HOLD     = PHYUPD_HOLD_DEF,
  parameter int unsigned PHYMSTR_HOLD    = PHYMSTR_HOLD_DEF,
  parameter int unsigned LP_ACK_DLY      = LP_ACK_DLY_DEF
) (
  input logic           clock,
  input logic           reset,
  dfi_phy_handshake_if.slave dfi
);

  localparam logic [3:0] CU_LOAD = 4'(CTRLUPD_ACK_DLY - 1);
  localparam logic [7:0] PU_LOAD = 8'(PHYUPD_HOLD - 1);
  localparam logic [7:0] PM_LOAD = 8'(PHYMSTR_HOLD - 1);

  ctrlupd_state_e cu_state_q, cu_state_d;
  logic [3:0]     cu_cnt_q, cu_cnt_d;

  phy_state_e     pu_state_q, pu_state_d;
  logic [7:0]     pu_cnt_q, pu_cnt_d;
  upd_type_t      pu_type_q, pu_type_d;

  phy_state_e     pm_state_q, pm_state_d;
  logic [7:0]     pm_cnt_q, pm_cnt_d;
  phymstr_info_t  pm_info_q, pm_info_d;

  logic cu_idle, pu_idle, pm_idle;
  logic pu_start, pm_start;

  assign cu_idle = (cu_state_q == CU_IDLE);
  assign pu_idle = (pu_state_q == PU_IDLE);
  assign pm_idle = (pm_state_q == PU_IDLE);

  // Arbitration: controller update beats both PHY requests, PHY update beats PHY master
  assign pu_start = dfi.phyupd_trig && cu_idle && !dfi.ctrlupd_req && pm_idle;
  assign pm_start = dfi.phymstr_trig && cu_idle && !dfi.ctrlupd_req && pu_idle && !dfi.phyupd_trig;

  always_ff @(posedge clock) begin
    if (reset) begin
      cu_state_q <= CU_IDLE;
      cu_cnt_q   <= '0;
      pu_state_q <= PU_IDLE;
      pu_cnt_q   <= '0;
      pu_type_q  <= '0;
      pm_state_q <= PU_IDLE;
      pm_cnt_q   <= '0;
      pm_info_q  <= '0;
    end else begin
      cu_state_q <= cu_state_d;
      cu_cnt_q   <= cu_cnt_d;
      pu_state_q <= pu_state_d;
      pu_cnt_q   <= pu_cnt_d;
      pu_type_q  <= pu_type_d;
      pm_state_q <= pm_state_d;
      pm_cnt_q   <= pm_cnt_d;
      pm_info_q  <= pm_info_d;
    end
  end

  always_comb begin
    cu_state_d = cu_state_q;
    cu_cnt_d   = cu_cnt_q;
    case (cu_state_q)
      CU_IDLE: begin
        if (dfi.ctrlupd_req && pu_idle && pm_idle) begin
          cu_state_d = CU_WAIT;
          cu_cnt_d   = CU_LOAD;
        end
      end
      CU_WAIT: begin
        if (!dfi.ctrlupd_req) begin
          cu_state_d = CU_IDLE;
          cu_cnt_d   = '0;
        end else if (cu_cnt_q == 4'd0) begin
          cu_state_d = CU_ACK;
        end else begin
          cu_cnt_d = cu_cnt_q - 4'd1;
        end
      end
      CU_ACK: begin
        if (!dfi.ctrlupd_req) cu_state_d = CU_IDLE;
      end
      default: begin
        cu_state_d = CU_IDLE;
        cu_cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    pu_state_d = pu_state_q;
    pu_cnt_d   = pu_cnt_q;
    pu_type_d  = pu_type_q;
    case (pu_state_q)
      PU_IDLE: begin
        if (pu_start) begin
          pu_state_d = PU_REQ;
          pu_type_d  = dfi.phyupd_type_in;
        end
      end
      PU_REQ: begin
        if (dfi.phyupd_ack) begin
          pu_state_d = PU_HOLD;
          pu_cnt_d   = PU_LOAD;
        end
      end
      PU_HOLD: begin
        if (pu_cnt_q == 8'd0) pu_state_d = PU_DROP;
        else                  pu_cnt_d   = pu_cnt_q - 8'd1;
      end
      PU_DROP: begin
        if (!dfi.phyupd_ack) begin
          pu_state_d = PU_IDLE;
          pu_type_d  = '0;
        end
      end
      default: pu_state_d = PU_IDLE;
    endcase
  end

  always_comb begin
    pm_state_d = pm_state_q;
    pm_cnt_d   = pm_cnt_q;
    pm_info_d  = pm_info_q;
    case (pm_state_q)
      PU_IDLE: begin
        if (pm_start) begin
          pm_state_d          = PU_REQ;
          pm_info_d.typ       = dfi.phymstr_type_in;
          pm_info_d.cs_state  = dfi.phymstr_cs_state_in;
          pm_info_d.state_sel = dfi.phymstr_state_sel_in;
        end
      end
      PU_REQ: begin
        if (dfi.phymstr_ack) begin
          pm_state_d = PU_HOLD;
          pm_cnt_d   = PM_LOAD;
        end
      end
      PU_HOLD: begin
        if (pm_cnt_q == 8'd0) pm_state_d = PU_DROP;
        else                  pm_cnt_d   = pm_cnt_q - 8'd1;
      end
      PU_DROP: begin
        if (!dfi.phymstr_ack) begin
          pm_state_d = PU_IDLE;
          pm_info_d  = '0;
        end
      end
      default: pm_state_d = PU_IDLE;
    endcase
  end

  assign dfi.ctrlupd_ack       = (cu_state_q == CU_ACK);
  assign dfi.phyupd_req        = (pu_state_q == PU_REQ) || (pu_state_q == PU_HOLD);
  assign dfi.phyupd_type       = pu_type_q;
  assign dfi.phymstr_req       = (pm_state_q == PU_REQ) || (pm_state_q == PU_HOLD);
  assign dfi.phymstr_type      = pm_info_q.typ;
  assign dfi.phymstr_cs_state  = pm_info_q.cs_state;
  assign dfi.phymstr_state_sel = pm_info_q.state_sel;
  assign dfi.busy              = !(cu_idle && pu_idle && pm_idle);

  dfi_lp_chan #(.ACK_DLY(LP_ACK_DLY)) u_lp_ctrl (
    .clock    (clock),
    .reset    (reset),
    .req      (dfi.lp_ctrl_req),
    .wakeup   (dfi.lp_ctrl_wakeup),
    .ack      (dfi.lp_ctrl_ack),
    .wakeup_q (dfi.lp_ctrl_wakeup_q)
  );

  dfi_lp_chan #(.ACK_DLY(LP_ACK_DLY)) u_lp_data (
    .clock    (clock),
    .reset    (reset),
    .req      (dfi.lp_data_req),
    .wakeup   (dfi.lp_data_wakeup),
    .ack      (dfi.lp_data_ack),
    .wakeup_q (dfi.lp_data_wakeup_q)
  );

endmodule

// File: tb/tb_dfi_phy_handshake.sv
// Bench for dfi_phy_handshake: vector table, directed corner sequences, random run against a timestamp model.
module tb_dfi_phy_handshake;

  localparam int CDLY = 2;
  localparam int PUH  = 4;
  localparam int PMH  = 4;
  localparam int LPD  = 1;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  dfi_phy_handshake_if dfi();

  dfi_phy_handshake #(
    .CTRLUPD_ACK_DLY (CDLY),
    .PHYUPD_HOLD     (PUH),
    .PHYMSTR_HOLD    (PMH),
    .LP_ACK_DLY      (LPD)
  ) dut (
    .clock (clock),
    .reset (reset),
    .dfi   (dfi)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    dfi.ctrlupd_req          = 1'b0;
    dfi.phyupd_trig          = 1'b0;
    dfi.phyupd_type_in       = 2'b00;
    dfi.phyupd_ack           = 1'b0;
    dfi.phymstr_trig         = 1'b0;
    dfi.phymstr_type_in      = 2'b00;
    dfi.phymstr_cs_state_in  = 2'b00;
    dfi.phymstr_state_sel_in = 1'b0;
    dfi.phymstr_ack          = 1'b0;
    dfi.lp_ctrl_req          = 1'b0;
    dfi.lp_ctrl_wakeup       = 6'h00;
    dfi.lp_data_req          = 1'b0;
    dfi.lp_data_wakeup       = 6'h00;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".ctrlupd_ack"}, {7'd0, dfi.ctrlupd_ack}, 8'd0);
    chk({tag, ".phyupd_req"}, {7'd0, dfi.phyupd_req}, 8'd0);
    chk({tag, ".phyupd_type"}, {6'd0, dfi.phyupd_type}, 8'd0);
    chk({tag, ".phymstr_req"}, {7'd0, dfi.phymstr_req}, 8'd0);
    chk({tag, ".phymstr_fields"}, {3'd0, dfi.phymstr_type, dfi.phymstr_cs_state, dfi.phymstr_state_sel}, 8'd0);
    chk({tag, ".lp_acks"}, {6'd0, dfi.lp_ctrl_ack, dfi.lp_data_ack}, 8'd0);
    chk({tag, ".lp_ctrl_wakeup_q"}, {2'd0, dfi.lp_ctrl_wakeup_q}, 8'd0);
    chk({tag, ".lp_data_wakeup_q"}, {2'd0, dfi.lp_data_wakeup_q}, 8'd0);
    chk({tag, ".busy"}, {7'd0, dfi.busy}, 8'd0);
  endtask

  // One row: inputs applied before an edge, expected outputs just after it
  typedef struct {
    logic       cu;
    logic       lp;
    logic [5:0] wk;
    logic       e_cu;
    logic       e_lp;
    logic [5:0] e_wq;
  } vec_t;

  vec_t tbl[14];

  // Reference model: one owner of the update path at a time, tracked by edge timestamps
  int          m_n, m_owner, m_t0, m_tack;
  logic [4:0]  m_cap;
  int          m_run[2];
  logic [5:0]  m_wq[2];

  task automatic model_reset();
    m_n = 0; m_owner = 0; m_t0 = 0; m_tack = -1; m_cap = '0;
    m_run[0] = 0; m_run[1] = 0; m_wq[0] = '0; m_wq[1] = '0;
  endtask

  task automatic model_edge();
    int hold;
    logic a;
    logic [1:0] lreq;
    logic [5:0] lwk[2];
    case (m_owner)
      0: begin
        if (dfi.ctrlupd_req) begin
          m_owner = 1; m_t0 = m_n;
        end else if (dfi.phyupd_trig) begin
          m_owner = 2; m_tack = -1; m_cap = {dfi.phyupd_type_in, 3'b000};
        end else if (dfi.phymstr_trig) begin
          m_owner = 3; m_tack = -1;
          m_cap = {dfi.phymstr_type_in, dfi.phymstr_cs_state_in, dfi.phymstr_state_sel_in};
        end
      end
      1: if (!dfi.ctrlupd_req) m_owner = 0;
      default: begin
        hold = (m_owner == 2) ? PUH : PMH;
        a    = (m_owner == 2) ? dfi.phyupd_ack : dfi.phymstr_ack;
        if (m_tack < 0) begin
          if (a) m_tack = m_n;
        end else if (m_n > m_tack + hold && !a) begin
          m_owner = 0; m_cap = '0;
        end
      end
    endcase
    lreq = {dfi.lp_data_req, dfi.lp_ctrl_req};
    lwk[0] = dfi.lp_ctrl_wakeup;
    lwk[1] = dfi.lp_data_wakeup;
    for (int c = 0; c < 2; c++) begin
      if (lreq[c]) begin
        if (m_run[c] < 1000) m_run[c]++;
      end else begin
        m_run[c] = 0;
      end
      if (m_run[c] == LPD + 1) m_wq[c] = lwk[c];
    end
  endtask

  task automatic model_compare();
    logic e_cu, e_pu, e_pm;
    int hold;
    hold = (m_owner == 2) ? PUH : PMH;
    e_cu = (m_owner == 1) && (m_n - m_t0 >= CDLY);
    e_pu = (m_owner == 2) && (m_tack < 0 || m_n < m_tack + hold);
    e_pm = (m_owner == 3) && (m_tack < 0 || m_n < m_tack + hold);
    chk("rnd.ctrlupd_ack", {7'd0, dfi.ctrlupd_ack}, {7'd0, e_cu});
    chk("rnd.phyupd_req", {7'd0, dfi.phyupd_req}, {7'd0, e_pu});
    chk("rnd.phyupd_type", {6'd0, dfi.phyupd_type}, (m_owner == 2) ? {6'd0, m_cap[4:3]} : 8'd0);
    chk("rnd.phymstr_req", {7'd0, dfi.phymstr_req}, {7'd0, e_pm});
    chk("rnd.phymstr_fields", {3'd0, dfi.phymstr_type, dfi.phymstr_cs_state, dfi.phymstr_state_sel},
        (m_owner == 3) ? {3'd0, m_cap} : 8'd0);
    chk("rnd.busy", {7'd0, dfi.busy}, {7'd0, (m_owner != 0)});
    chk("rnd.lp_ctrl_ack", {7'd0, dfi.lp_ctrl_ack}, {7'd0, (m_run[0] >= LPD + 1)});
    chk("rnd.lp_data_ack", {7'd0, dfi.lp_data_ack}, {7'd0, (m_run[1] >= LPD + 1)});
    chk("rnd.lp_ctrl_wakeup_q", {2'd0, dfi.lp_ctrl_wakeup_q}, {2'd0, m_wq[0]});
    chk("rnd.lp_data_wakeup_q", {2'd0, dfi.lp_data_wakeup_q}, {2'd0, m_wq[1]});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    chk_all_zero("reset");

    // ctrlupd delay and early drop, lp_ctrl delay / short pulse / wakeup capture
    tbl[0]  = '{1'b1, 1'b1, 6'h15, 1'b0, 1'b0, 6'h00};
    tbl[1]  = '{1'b1, 1'b1, 6'h15, 1'b0, 1'b1, 6'h15};
    tbl[2]  = '{1'b1, 1'b1, 6'h2A, 1'b1, 1'b1, 6'h15};
    tbl[3]  = '{1'b1, 1'b0, 6'h2A, 1'b1, 1'b0, 6'h15};
    tbl[4]  = '{1'b0, 1'b1, 6'h07, 1'b0, 1'b0, 6'h15};
    tbl[5]  = '{1'b0, 1'b0, 6'h07, 1'b0, 1'b0, 6'h15};
    tbl[6]  = '{1'b1, 1'b0, 6'h00, 1'b0, 1'b0, 6'h15};
    tbl[7]  = '{1'b0, 1'b0, 6'h00, 1'b0, 1'b0, 6'h15};
    tbl[8]  = '{1'b0, 1'b1, 6'h3F, 1'b0, 1'b0, 6'h15};
    tbl[9]  = '{1'b0, 1'b1, 6'h21, 1'b0, 1'b1, 6'h21};
    tbl[10] = '{1'b1, 1'b1, 6'h3F, 1'b0, 1'b1, 6'h21};
    tbl[11] = '{1'b1, 1'b0, 6'h3F, 1'b0, 1'b0, 6'h21};
    tbl[12] = '{1'b1, 1'b0, 6'h00, 1'b1, 1'b0, 6'h21};
    tbl[13] = '{1'b0, 1'b0, 6'h00, 1'b0, 1'b0, 6'h21};
    for (int i = 0; i < 14; i++) begin
      dfi.ctrlupd_req    = tbl[i].cu;
      dfi.lp_ctrl_req    = tbl[i].lp;
      dfi.lp_ctrl_wakeup = tbl[i].wk;
      tick();
      chk($sformatf("tbl[%0d].ctrlupd_ack", i), {7'd0, dfi.ctrlupd_ack}, {7'd0, tbl[i].e_cu});
      chk($sformatf("tbl[%0d].lp_ctrl_ack", i), {7'd0, dfi.lp_ctrl_ack}, {7'd0, tbl[i].e_lp});
      chk($sformatf("tbl[%0d].lp_ctrl_wakeup_q", i), {2'd0, dfi.lp_ctrl_wakeup_q}, {2'd0, tbl[i].e_wq});
    end
    idle_inputs();
    tick();

    // phyupd full handshake, type 10, ack 3 cycles after req
    dfi.phyupd_trig = 1'b1; dfi.phyupd_type_in = 2'b10;
    tick();
    dfi.phyupd_trig = 1'b0; dfi.phyupd_type_in = 2'b01;
    chk("pu.req_rise", {7'd0, dfi.phyupd_req}, 8'd1);
    chk("pu.type", {6'd0, dfi.phyupd_type}, 8'd2);
    chk("pu.busy", {7'd0, dfi.busy}, 8'd1);
    tick(); chk("pu.req_wait1", {7'd0, dfi.phyupd_req}, 8'd1);
    tick(); chk("pu.req_wait2", {7'd0, dfi.phyupd_req}, 8'd1);
    dfi.phyupd_ack = 1'b1;
    tick(); chk("pu.hold0", {7'd0, dfi.phyupd_req}, 8'd1);
    for (int i = 1; i < PUH; i++) begin
      if (i == 2) dfi.phyupd_trig = 1'b1;
      tick();
      dfi.phyupd_trig = 1'b0;
      chk($sformatf("pu.hold%0d", i), {7'd0, dfi.phyupd_req}, 8'd1);
      chk($sformatf("pu.hold_type%0d", i), {6'd0, dfi.phyupd_type}, 8'd2);
    end
    tick();
    chk("pu.req_drop", {7'd0, dfi.phyupd_req}, 8'd0);
    chk("pu.drop_type", {6'd0, dfi.phyupd_type}, 8'd2);
    chk("pu.drop_busy", {7'd0, dfi.busy}, 8'd1);
    tick(); chk("pu.drop_wait_busy", {7'd0, dfi.busy}, 8'd1);
    dfi.phyupd_ack = 1'b0;
    tick();
    chk("pu.idle_busy", {7'd0, dfi.busy}, 8'd0);
    chk("pu.idle_type", {6'd0, dfi.phyupd_type}, 8'd0);

    // phymstr handshake, retrigger and phyupd trigger mid-handshake are ignored
    dfi.phymstr_trig = 1'b1; dfi.phymstr_type_in = 2'b11;
    dfi.phymstr_cs_state_in = 2'b01; dfi.phymstr_state_sel_in = 1'b1;
    tick();
    chk("pm.req_rise", {7'd0, dfi.phymstr_req}, 8'd1);
    chk("pm.fields", {3'd0, dfi.phymstr_type, dfi.phymstr_cs_state, dfi.phymstr_state_sel}, 8'b000_11_01_1);
    dfi.phymstr_type_in = 2'b00; dfi.phymstr_cs_state_in = 2'b10; dfi.phymstr_state_sel_in = 1'b0;
    dfi.phyupd_trig = 1'b1;
    tick();
    idle_inputs();
    chk("pm.retrig_fields", {3'd0, dfi.phymstr_type, dfi.phymstr_cs_state, dfi.phymstr_state_sel}, 8'b000_11_01_1);
    chk("pm.phyupd_blocked", {7'd0, dfi.phyupd_req}, 8'd0);
    dfi.phymstr_ack = 1'b1;
    tick();
    for (int i = 1; i < PMH; i++) begin
      tick();
      chk($sformatf("pm.hold%0d", i), {7'd0, dfi.phymstr_req}, 8'd1);
    end
    tick();
    chk("pm.req_drop", {7'd0, dfi.phymstr_req}, 8'd0);
    chk("pm.drop_cs", {6'd0, dfi.phymstr_cs_state}, 8'd1);
    dfi.phymstr_ack = 1'b0;
    tick();
    chk("pm.idle_busy", {7'd0, dfi.busy}, 8'd0);
    chk("pm.idle_fields", {3'd0, dfi.phymstr_type, dfi.phymstr_cs_state, dfi.phymstr_state_sel}, 8'd0);

    // ctrlupd_req and phyupd_trig together: controller update wins
    dfi.ctrlupd_req = 1'b1; dfi.phyupd_trig = 1'b1; dfi.phyupd_type_in = 2'b01;
    tick();
    dfi.phyupd_trig = 1'b0;
    chk("arb.pu_blocked", {7'd0, dfi.phyupd_req}, 8'd0);
    chk("arb.busy", {7'd0, dfi.busy}, 8'd1);
    tick(); chk("arb.cu_wait", {7'd0, dfi.ctrlupd_ack}, 8'd0);
    tick(); chk("arb.cu_ack", {7'd0, dfi.ctrlupd_ack}, 8'd1);
    chk("arb.pu_still_low", {7'd0, dfi.phyupd_req}, 8'd0);
    dfi.ctrlupd_req = 1'b0;
    tick();
    chk("arb.cu_drop", {7'd0, dfi.ctrlupd_ack}, 8'd0);
    chk("arb.idle", {7'd0, dfi.busy}, 8'd0);

    // both PHY triggers together: phyupd wins; then reset during HOLD with lp_data acked
    dfi.phyupd_trig = 1'b1; dfi.phymstr_trig = 1'b1; dfi.phyupd_type_in = 2'b11;
    dfi.lp_data_req = 1'b1; dfi.lp_data_wakeup = 6'h2A;
    tick();
    dfi.phyupd_trig = 1'b0; dfi.phymstr_trig = 1'b0;
    chk("both.pu_wins", {6'd0, dfi.phyupd_req, dfi.phymstr_req}, 8'b10);
    dfi.phyupd_ack = 1'b1;
    tick();
    chk("both.lp_data_ack", {7'd0, dfi.lp_data_ack}, 8'd1);
    chk("both.lp_data_wq", {2'd0, dfi.lp_data_wakeup_q}, 8'h2A);
    tick();
    chk("rst.in_hold", {7'd0, dfi.phyupd_req}, 8'd1);
    reset = 1'b1;
    tick();
    chk_all_zero("rst_mid");
    reset = 1'b0;
    idle_inputs();
    tick();

    // randomized run against the model
    do_reset();
    model_reset();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if ($urandom_range(7) == 0) dfi.ctrlupd_req = ~dfi.ctrlupd_req;
      dfi.phyupd_trig          = ($urandom_range(7) == 0);
      dfi.phymstr_trig         = ($urandom_range(7) == 0);
      dfi.phyupd_type_in       = 2'($urandom);
      dfi.phymstr_type_in      = 2'($urandom);
      dfi.phymstr_cs_state_in  = 2'($urandom);
      dfi.phymstr_state_sel_in = 1'($urandom);
      if ($urandom_range(3) == 0) dfi.phyupd_ack  = ~dfi.phyupd_ack;
      if ($urandom_range(3) == 0) dfi.phymstr_ack = ~dfi.phymstr_ack;
      if ($urandom_range(4) == 0) dfi.lp_ctrl_req = ~dfi.lp_ctrl_req;
      if ($urandom_range(4) == 0) dfi.lp_data_req = ~dfi.lp_data_req;
      dfi.lp_ctrl_wakeup = 6'($urandom);
      dfi.lp_data_wakeup = 6'($urandom);
      model_edge();
      tick();
      model_compare();
      m_n++;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
